// File: rtl/breakout_bounce_arbiter.sv
// breakout_bounce_arbiter
//   Arbitrates per-column block-hit direction requests and owns the ball
//   direction registers. One column wins per bounce event (round-robin from
//   ptr), its captured flags are applied to dir_x/dir_y, and a frame-based
//   cooldown then masks further requests so one collision flips the ball once.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   refr_tick     one-cycle pulse per video frame (cooldown time base)
//   serve         one-cycle pulse: new ball served (dir right/up, back to IDLE)
//   hit_u/d/l/r   per-column moveU/moveD/moveL/moveR, bit i = column i
//   dir_x         1 = right, 0 = left
//   dir_y         1 = down,  0 = up
//   bounce_pulse  one-cycle strobe when a bounce is applied
//   bounce_col    column whose request was last applied (zero-extended)
//   bounce_count  applied bounces, saturating
//   busy          high in APPLY and COOLDOWN
module breakout_bounce_arbiter #(
  parameter int NCOL           = 5,
  parameter int COOLDOWN_TICKS = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refr_tick,
  input  logic             serve,
  input  logic [NCOL-1:0]  hit_u,
  input  logic [NCOL-1:0]  hit_d,
  input  logic [NCOL-1:0]  hit_l,
  input  logic [NCOL-1:0]  hit_r,
  output logic             dir_x,
  output logic             dir_y,
  output logic             bounce_pulse,
  output logic [2:0]       bounce_col,
  output logic [CNT_W-1:0] bounce_count,
  output logic             busy
);

  localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, COOLDOWN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [3:0]      cd;
  logic [NCOL-1:0] req;
  logic            sel_vld;
  logic [PW-1:0]   sel_col;
  int              idx;

  logic [PW-1:0]   win_col_p0;
  logic            win_u_p0, win_d_p0, win_l_p0, win_r_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    return (w == PW'(NCOL - 1)) ? '0 : w + 1'b1;
  endfunction

  assign req  = hit_u | hit_d | hit_l | hit_r;
  assign busy = (state != IDLE);

  // Round-robin pick: first requesting column scanning upward from ptr, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_col = '0;
    idx     = 0;
    for (int k = 0; k < NCOL; k++) begin
      idx = (int'(ptr) + k) % NCOL;
      if (!sel_vld && req[PW'(idx)]) begin
        sel_vld = 1'b1;
        sel_col = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sel_vld) state_nxt = APPLY;
      APPLY:    state_nxt = COOLDOWN;
      COOLDOWN: if (refr_tick && cd <= 4'd1) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // serve drops any pending hit and any cooldown in progress
    if (serve) state_nxt = IDLE;
  end

  // Stage p0: capture the winning column and its flags (consumed in APPLY)
  always_ff @(posedge clk) begin
    if (state == IDLE && sel_vld) begin
      win_col_p0 <= sel_col;
      win_u_p0   <= hit_u[sel_col];
      win_d_p0   <= hit_d[sel_col];
      win_l_p0   <= hit_l[sel_col];
      win_r_p0   <= hit_r[sel_col];
    end
  end

  // Stage p1: apply captured flags, cooldown bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cd           <= '0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b0;
      bounce_pulse <= 1'b0;
      bounce_col   <= '0;
      bounce_count <= '0;
    end else begin
      state        <= state_nxt;
      // a serve landing on the APPLY cycle still counts the bounce but
      // suppresses the strobe, since the direction it would announce is lost
      bounce_pulse <= (state == APPLY) && !serve;
      if (state == APPLY) begin
        bounce_col   <= 3'(win_col_p0);
        bounce_count <= sat_inc(bounce_count);
        ptr          <= next_ptr(win_col_p0);
      end
      if (serve) begin
        dir_x <= 1'b1;
        dir_y <= 1'b0;
        cd    <= '0;
      end else begin
        case (state)
          APPLY: begin
            if (win_r_p0 && win_l_p0) dir_x <= ~dir_x;
            else if (win_r_p0)        dir_x <= 1'b1;
            else if (win_l_p0)        dir_x <= 1'b0;
            if (win_u_p0 && win_d_p0) dir_y <= ~dir_y;
            else if (win_d_p0)        dir_y <= 1'b1;
            else if (win_u_p0)        dir_y <= 1'b0;
            cd <= 4'(COOLDOWN_TICKS);
          end
          COOLDOWN: if (refr_tick && cd != 4'd0) cd <= cd - 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
